// File: rtl/wb_sram_slave.sv
// Wishbone classic slave in front of an on-chip synchronous RAM.
// Byte-lane writes, optional read wait states, and an error response for
// out-of-range addresses. If the master drops cyc while a read is waiting,
// the transfer is abandoned without a response.
module wb_sram_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 256,
    parameter int READ_WAIT  = 0
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [31:0]               wb_adr_i,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    output logic                      wb_ack_o,
    output logic                      wb_err_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o
);

    localparam int SEL_W = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(SEL_W);
    localparam int IDX_W = $clog2(WORDS);

    // The wait counter is loaded with READ_WAIT-1 so that the read ack
    // lands exactly READ_WAIT cycles after the zero-wait case.
    localparam logic [1:0] WAIT_LOAD = (READ_WAIT > 0) ? 2'(READ_WAIT - 1) : 2'd0;

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       wait_q, wait_d;
    logic             resp_err_q, resp_err_d;

    logic [31:0]      word_addr;
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             req;
    logic             do_write;
    logic             do_read;

    logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

    // Address decode. The word address is the byte address without its lane
    // bits. A single compare against WORDS covers both an index past the end
    // and a set upper bit, because WORDS never exceeds 2**IDX_W.
    always_comb begin
        word_addr = wb_adr_i >> LSB;
        in_range  = (word_addr < 32'(WORDS));
        idx       = word_addr[IDX_W-1:0];
        req       = wb_cyc_i & wb_stb_i;
    end

    // Next-state logic, RAM strobes and the response outputs.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d    = state_q;
        wait_d     = wait_q;
        resp_err_d = resp_err_q;
        do_write   = 1'b0;
        do_read    = 1'b0;
        wb_ack_o   = 1'b0;
        wb_err_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RESP;
                    if (!in_range) begin
                        resp_err_d = 1'b1;
                    end else if (wb_we_i) begin
                        resp_err_d = 1'b0;
                        do_write   = 1'b1;
                    end else begin
                        resp_err_d = 1'b0;
                        do_read    = 1'b1;
                        if (READ_WAIT > 0) begin
                            state_d = RWAIT;
                            wait_d  = WAIT_LOAD;
                        end
                    end
                end
            end
            RWAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (wait_q == 2'd0) begin
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            RESP: begin
                // req is deliberately not sampled here, so a strobe held
                // high gets one response per accepted transfer.
                wb_ack_o = ~resp_err_q;
                wb_err_o = resp_err_q;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset abandons any transfer in flight.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (wb_rst_i) begin
            state_q    <= IDLE;
            wait_q     <= 2'd0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Read data register. It is loaded only when a read is accepted, so
    // writes and error responses leave it unchanged.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_dat_o <= '0;
        end else if (do_read) begin
            wb_dat_o <= mem[idx];
        end
    end

    // RAM write port with per-byte lane enables.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: the RAM array has no reset. Contents survive wb_rst_i, and the array can still map to a RAM macro. Reset only blocks a write presented in the same cycle.
        if (do_write && !wb_rst_i) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (wb_sel_i[i]) begin
                    mem[idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave. Two instances run on one clock:
// dut 0 has 200 words and no read wait, and dut 1 has 256 words and two
// read wait states. A word-array model tracks the expected RAM contents and
// the expected value of the read-data register.
module tb_wb_sram_slave;

    logic        clk;
    logic [1:0]  rst, cyc, stb, we, ack, err;
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] rdat [2];

    logic [31:0] model_mem [2][256];
    logic [31:0] last_rd   [2];
    bit          last_known[2];

    int n_cmp = 0;
    int n_bad = 0;

    wb_sram_slave #(.DATA_WIDTH(32), .WORDS(200), .READ_WAIT(0)) dut0 (
        .wb_clk_i (clk),     .wb_rst_i (rst[0]),  .wb_adr_i (adr[0]),
        .wb_dat_i (wdat[0]), .wb_sel_i (sel[0]),  .wb_we_i  (we[0]),
        .wb_cyc_i (cyc[0]),  .wb_stb_i (stb[0]),  .wb_ack_o (ack[0]),
        .wb_err_o (err[0]),  .wb_dat_o (rdat[0])
    );

    wb_sram_slave #(.DATA_WIDTH(32), .WORDS(256), .READ_WAIT(2)) dut1 (
        .wb_clk_i (clk),     .wb_rst_i (rst[1]),  .wb_adr_i (adr[1]),
        .wb_dat_i (wdat[1]), .wb_sel_i (sel[1]),  .wb_we_i  (we[1]),
        .wb_cyc_i (cyc[1]),  .wb_stb_i (stb[1]),  .wb_ack_o (ack[1]),
        .wb_err_o (err[1]),  .wb_dat_o (rdat[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int words_of(input int d);
        return (d == 0) ? 200 : 256;
    endfunction

    function automatic int rw_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle_bus(input int d);
        cyc[d]  = 1'b0;
        stb[d]  = 1'b0;
        we[d]   = 1'b0;
        adr[d]  = 32'h0;
        wdat[d] = 32'h0;
        sel[d]  = 4'h0;
    endtask

    // One complete classic transfer. Checks that the bus stays quiet during
    // wait cycles, that the response type and timing are right, that the read
    // data is right, and that the response lasts one cycle.
    task automatic xfer(input int d, input bit w, input logic [31:0] a,
                        input logic [31:0] dat, input logic [3:0] s);
        logic [31:0] widx;
        bit          oor;
        int          lat;
        widx = a >> 2;
        oor  = (widx >= 32'(words_of(d)));
        lat  = (oor || w) ? 1 : 1 + rw_of(d);

        @(negedge clk);
        adr[d] = a; wdat[d] = dat; sel[d] = s; we[d] = w;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        @(posedge clk);                     // acceptance edge
        for (int k = 1; k < lat; k++) begin
            #1;
            check("wait_quiet", {ack[d], err[d]}, 2'b00);
            @(posedge clk);
        end
        #1;
        check("ack", ack[d], !oor);
        check("err", err[d], oor);
        if (!oor && !w) begin
            last_rd[d]    = model_mem[d][widx[7:0]];
            last_known[d] = 1'b1;
        end
        if (last_known[d]) check("dat_o", rdat[d], last_rd[d]);
        if (!oor && w) begin
            for (int i = 0; i < 4; i++)
                if (s[i]) model_mem[d][widx[7:0]][8*i +: 8] = dat[8*i +: 8];
        end
        @(negedge clk);
        idle_bus(d);
        @(posedge clk);
        #1;
        check("one_pulse", {ack[d], err[d]}, 2'b00);
    endtask

    initial begin
        logic [31:0] a;
        int          d;
        int          kind;

        idle_bus(0);
        idle_bus(1);
        rst = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ack", ack[i], 1'b0);
            check("rst_err", err[i], 1'b0);
            check("rst_dat", rdat[i], 32'h0);
            last_rd[i]    = 32'h0;
            last_known[i] = 1'b1;
        end
        rst = 2'b00;

        // Fill both RAMs so every later read has a known expected value.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < words_of(i); j++)
                xfer(i, 1'b1, 32'(j * 4), $urandom, 4'hF);

        // Full-word write and read-back, then a partial-lane write.
        xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("plan_full_word", rdat[0], 32'hDEADBEEF);
        xfer(0, 1'b1, 32'h10, 32'h11223344, 4'h5);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0);
        check("plan_byte_lane", rdat[0], 32'hDE22BE44);

        // Out-of-range writes (index == WORDS, and an upper address bit) and a
        // read. The last valid word and word 0 must be left unchanged.
        xfer(0, 1'b1, 32'h320, 32'hA5A5A5A5, 4'hF);
        xfer(0, 1'b1, 32'h8000_0000, 32'h5A5A5A5A, 4'hF);
        xfer(0, 1'b0, 32'h320, 32'h0, 4'h0);
        xfer(0, 1'b0, 32'(199 * 4), 32'h0, 4'h0);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Read with two wait states.
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0);

        // Back-to-back reads with cyc/stb held high: expect acks two cycles apart.
        @(negedge clk);
        adr[0] = 32'h0; we[0] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (c % 2 == 0) begin
                check("b2b_ack", {ack[0], err[0]}, 2'b10);
                check("b2b_dat", rdat[0], model_mem[0][c / 2]);
            end else begin
                check("b2b_gap", {ack[0], err[0]}, 2'b00);
            end
            @(negedge clk);
            if (c == 6) idle_bus(0);
            else if (c % 2 == 0) adr[0] = 32'((c / 2 + 1) * 4);
        end
        last_rd[0] = model_mem[0][3];

        // Abort: drop cyc during the wait states. No response may follow.
        @(negedge clk);
        adr[1] = 32'h24; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_bus(1);
        repeat (6) begin
            @(posedge clk);
            #1;
            check("abort_quiet", {ack[1], err[1]}, 2'b00);
        end
        last_known[1] = 1'b0;
        xfer(1, 1'b0, 32'h18, 32'h0, 4'h0);

        // Reset while a read is waiting: the pending response is dropped and
        // the read data register is cleared.
        @(negedge clk);
        adr[1] = 32'h20; we[1] = 1'b0; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_bus(1);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        check("rwait_rst_resp", {ack[1], err[1]}, 2'b00);
        check("rwait_rst_dat", rdat[1], 32'h0);
        @(negedge clk);
        rst[1] = 1'b0;
        last_rd[1] = 32'h0;
        last_known[1] = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_quiet", {ack[1], err[1]}, 2'b00);
        end
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0);

        // A write presented in the same cycle as reset must not be performed.
        @(negedge clk);
        adr[1] = 32'h14; wdat[1] = ~model_mem[1][5]; sel[1] = 4'hF;
        we[1] = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1; rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle_bus(1);
        rst[1] = 1'b0;
        last_rd[1] = 32'h0;
        @(posedge clk);
        #1;
        check("rst_write_resp", {ack[1], err[1]}, 2'b00);
        xfer(1, 1'b0, 32'h14, 32'h0, 4'h0);

        // Random mix of reads, writes and out-of-range accesses on both slaves.
        for (int n = 0; n < 400; n++) begin
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            if (kind == 0)
                a = 32'((words_of(d) + int'($urandom_range(0, 3))) * 4);
            else if (kind == 1)
                a = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            else
                a = 32'(int'($urandom_range(0, words_of(d) - 1)) * 4) | 32'($urandom_range(0, 3));
            xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
